// File: rtl/uart_debug_rx.sv
// uart_debug_rx: 8N1 UART receiver with valid/ready holding register, framing-error pulse and sticky overrun; define UART_RX_MAJORITY_EN for 2-of-3 majority sampling
module uart_debug_rx #(
    parameter int CLK_HZ       = 27000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clear_err,
    output logic       busy
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    localparam logic [8:0] BIT_END = 9'(CLKS_PER_BIT - 1);

    state_t      r_state, w_next;
    logic [1:0]  r_sync;
    logic [8:0]  r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift, r_data;
    logic        r_valid, r_ovr, r_ferr;
    logic        w_rxs, w_samp, w_clr, w_bit_en, w_deliver, w_ferr, w_load;

    assign w_rxs = r_sync[1];

`ifdef UART_RX_MAJORITY_EN
    localparam logic [8:0] START_END = 9'(HALF_BIT);
    logic [1:0] r_hist;
    // Two previous synced samples; the vote is taken one cycle after the nominal sample point
    always_ff @(posedge clk) begin
        if (rst) r_hist <= 2'b11;
        else     r_hist <= {r_hist[0], w_rxs};
    end
    assign w_samp = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
    localparam logic [8:0] START_END = 9'(HALF_BIT - 1);
    assign w_samp = w_rxs;
`endif

    // Two-flop synchronizer for the asynchronous line; idles high
    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], uart_rx};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and per-cycle strobes for the datapath
    always_comb begin
        w_next    = r_state;
        w_clr     = 1'b0;
        w_bit_en  = 1'b0;
        w_deliver = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clr  = !w_rxs;
                w_next = w_rxs ? S_IDLE : S_START;
            end
            S_START: if (r_cnt == START_END) begin
                w_clr  = 1'b1;
                w_next = w_samp ? S_IDLE : S_DATA;
            end
            S_DATA: if (r_cnt == BIT_END) begin
                w_clr    = 1'b1;
                w_bit_en = 1'b1;
                w_next   = (r_idx == 3'd7) ? S_STOP : S_DATA;
            end
            S_STOP: if (r_cnt == BIT_END) begin
                w_clr     = 1'b1;
                w_deliver = w_samp;
                w_ferr    = !w_samp;
                w_next    = w_samp ? S_IDLE : S_BREAK;
            end
            S_BREAK: w_next = w_rxs ? S_IDLE : S_BREAK;
            default: w_next = S_IDLE;
        endcase
    end

    // A finished byte is loaded when the holding register is empty or being drained this cycle
    assign w_load = w_deliver && (!r_valid || rx_ready);

    // Bit timing, shift register, holding register and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_cnt   <= w_clr ? 9'd0 : r_cnt + 9'd1;
            r_idx   <= (r_state == S_DATA) ? r_idx + 3'(w_bit_en) : 3'd0;
            if (w_bit_en) r_shift[r_idx] <= w_samp;
            if (w_load) r_data <= r_shift;
            r_valid <= w_load || (r_valid && !rx_ready);
            r_ovr   <= (w_deliver && r_valid && !rx_ready) || (r_ovr && !clear_err);
            r_ferr  <= w_ferr;
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign overrun   = r_ovr;
    assign frame_err = r_ferr;
    assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_debug_rx.sv
// tb_uart_debug_rx: randomized and directed scoreboard bench for uart_debug_rx
`timescale 1ns/1ps
module tb_uart_debug_rx;
    localparam int CPB  = 27000000 / 115200;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 2 + HALF + 9 * CPB + 2;
`else
    localparam int LAT = 2 + HALF + 9 * CPB + 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       clear_err = 1'b0;
    logic       busy;

    uart_debug_rx dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
        .overrun(overrun), .clear_err(clear_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int ferr_cnt = 0;
    int valid_cycles = 0;
    int lat_start = -1;
    int lat_seen = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic monitor();
        logic prev_valid, prev_ready;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (frame_err) ferr_cnt++;
                if (rx_valid) valid_cycles++;
                if (rx_valid && (!prev_valid || prev_ready)) begin
                    if (lat_start >= 0 && lat_seen < 0) lat_seen = cyc - lat_start;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h expected none", rx_data);
                    end else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
                prev_valid = rx_valid;
                prev_ready = rx_ready;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            tick(CPB);
        end
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        tick(n);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 30 * CPB) begin
            tick(1);
            w++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_valid"}, 32'(rx_valid), 0);
        check({tag, "_rx_data"}, 32'(rx_data), 0);
        check({tag, "_frame_err"}, 32'(frame_err), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ferr0, vc0, w;
        logic [7:0] b;
        fork
            monitor();
        join_none
        tick(5);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(20);

        exp_q.push_back(8'h48);
        @(posedge clk);
        #1;
        lat_seen = -1;
        lat_start = cyc;
        send_byte(8'h48, 1'b1);
        check("latency", lat_seen, LAT);
        check("single_valid_held", 32'(rx_valid), 1);
        check("single_overrun", 32'(overrun), 0);
        check("single_frame_err", ferr_cnt, 0);
        lat_start = -1;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("single_consumed", 32'(rx_valid), 0);

        rx_ready = 1'b1;
        vc0 = valid_cycles;
        foreach (exp_q[i]) ;
        exp_q.push_back(8'h48); exp_q.push_back(8'h65); exp_q.push_back(8'h6C);
        exp_q.push_back(8'h6C); exp_q.push_back(8'h6F);
        send_byte(8'h48, 1'b1); send_byte(8'h65, 1'b1); send_byte(8'h6C, 1'b1);
        send_byte(8'h6C, 1'b1); send_byte(8'h6F, 1'b1);
        idle(CPB);
        drain();
        check("hello_pulse_cycles", valid_cycles - vc0, 5);

        ferr0 = ferr_cnt;
        uart_rx = 1'b0;
        tick(50);
        uart_rx = 1'b1;
        w = 0;
        while (busy && w < 120) begin
            tick(1);
            w++;
        end
        check("glitch_busy", 32'(busy), 0);
        idle(CPB);
        check("glitch_frame_err", ferr_cnt - ferr0, 0);

        send_byte(8'h55, 1'b0);
        tick(1500);
        check("break_busy", 32'(busy), 1);
        tick(1500);
        idle(CPB);
        check("framing_pulses", ferr_cnt - ferr0, 1);
        check("framing_idle", 32'(busy), 0);
        exp_q.push_back(8'h41);
        send_byte(8'h41, 1'b1);
        idle(CPB);
        drain();

        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(CPB);
        check("ovr_valid", 32'(rx_valid), 1);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_flag", 32'(overrun), 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("ovr_consumed", 32'(rx_valid), 0);
        check("ovr_sticky", 32'(overrun), 1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("ovr_cleared", 32'(overrun), 0);
        drain();

        rx_ready = 1'b1;
        b = 8'h3C;
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = b[4];
        tick(HALF);
        rst = 1'b1;
        uart_rx = 1'b1;
        tick(3);
        check_reset_outputs("midreset");
        rst = 1'b0;
        idle(2 * CPB);
        check("midreset_quiet", 32'(rx_valid), 0);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        idle(CPB);
        drain();

        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_byte(b, 1'b1);
            idle($urandom_range(0, 300));
        end
        idle(CPB);
        drain();
        check("total_frame_err", ferr_cnt, 1);
        check("final_overrun", 32'(overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_debug_rx.md
Name: uart_debug_rx

Overview:
- 8N1 UART receiver. It is the receive end of the debug UART link that our debug transmitter drives at 115200 baud from the 27 MHz board clock.
- Turns the serial line into bytes and presents them through a valid/ready holding register.
- Flags framing errors and overruns.
- Used for host-to-FPGA debug commands, and as a synthesizable loopback checker that replaces the behavioural monitor in benches.

Parameters:
- CLK_HZ, 27000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits per second.
- CLKS_PER_BIT, CLK_HZ/BAUD (truncated, 234 at defaults), clocks per bit period.
- HALF_BIT, CLKS_PER_BIT/2 (truncated, 117), start-bit mid-point offset.

Ports:
- clk  input  1  system clock, 27 MHz.
- rst  input  1  synchronous reset, active-high.
- uart_rx  input  1  asynchronous serial line; idles high.
- rx_data  output  8  received byte; valid only while rx_valid=1.
- rx_valid  output  1  byte held; stays high until consumed.
- rx_ready  input  1  consumer accepts the byte on a cycle where rx_valid&&rx_ready.
- frame_err  output  1  one-cycle pulse when a bad stop bit is seen.
- overrun  output  1  sticky flag: a completed byte was dropped because the holding register was full.
- clear_err  input  1  clears overrun; takes effect on the next clock edge.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE.
  - Both synchronizer flops and the shift register reset to all-ones/zero respectively.
  - rst asserted mid-frame aborts the frame; the partial byte is never delivered.
- Input synchronizer: 2-flop synchronizer on uart_rx; all logic uses the synced bit rxs, which lags the pin by 2 cycles.
- Bit counter: 9-bit, counting 0..CLKS_PER_BIT-1. Bit index: 3-bit.
- State machine:
  - IDLE: when rxs==0, go to START and clear the counter.
  - START: when counter==HALF_BIT-1, sample rxs.
    - rxs=0: go to DATA, clear counter and bit index.
    - rxs=1: glitch; return to IDLE with no outputs.
  - DATA: when counter==CLKS_PER_BIT-1, sample rxs into shift[bit index] (LSB first) and clear the counter.
    - After bit 7, go to STOP.
  - STOP: when counter==CLKS_PER_BIT-1, sample rxs.
    - rxs=1: deliver the byte (see Delivery), go to IDLE.
    - rxs=0: pulse frame_err for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. No start detection happens while the line is held low.
- Delivery:
  - If rx_valid==0, or rx_valid&&rx_ready in the same cycle: load rx_data and set rx_valid=1 on the next edge.
  - Else: keep the old rx_data and set overrun=1 (sticky).
- Handshake: rx_valid clears on the edge after a cycle with rx_valid&&rx_ready, unless a delivery happens in that same cycle (then it stays 1 with the new data).
- Overrun precedence: if clear_err and a new overrun occur in the same cycle, overrun ends at 1 (set wins).
- Latency: a successful byte gives rx_valid=1 exactly 2+HALF_BIT+9*CLKS_PER_BIT+1 cycles (2226 at defaults) after the start-bit falling edge at the pin.
- Back-to-back frames: resync happens at each start edge, so the receiver tolerates ±2% baud mismatch.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each START/DATA/STOP sample is the 2-of-3 majority of rxs taken at the sample point −1, 0 and +1 cycle. The state transition occurs at sample point +1, so the latency above grows by 1 cycle (2227).
- Undefined: single-sample at the sample point, exactly as specified above. The majority logic is not synthesized.

Test Plan:
- Single byte: drive 0x48 at 234 clk/bit, rx_ready=0. Expect rx_data=0x48 and rx_valid rising 2226 cycles after the start edge (2227 with the macro). frame_err=0, overrun=0.
- String: drive "Hello" (0x48 0x65 0x6C 0x6C 0x6F) back-to-back with rx_ready=1. Expect exactly 5 one-cycle rx_valid pulses carrying those values in order.
- Glitch: pull the line low for 50 cycles, then high. Expect no rx_valid, no frame_err, busy back to 0 within 120 cycles.
- Framing: send 0x55 with stop bit 0 and hold low for 3000 cycles, then release and send 0x41. Expect:
  - one frame_err pulse, 0x55 not delivered;
  - no start detected during the low hold;
  - 0x41 then received normally.
- Overrun: send 0x11 then 0x22 with rx_ready=0. Expect rx_data=0x11 and overrun=1. Then rx_ready=1 for 1 cycle: rx_valid goes to 0. Then clear_err: overrun goes to 0.
- Reset mid-frame: assert rst during bit 4 of 0x3C, release, send 0xA5. Expect no partial byte delivered, all outputs at reset values, then rx_data=0xA5.
